// File: rtl/rheed_pkg.sv
// Shared types and helpers for the RHEED frame scheduler.
package rheed_pkg;

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} frm_state_t;

  function automatic int beats_per_frame(input int num_crops, input int out_rows,
                                         input int out_cols);
    return num_crops * out_rows * out_cols;
  endfunction

endpackage

// File: rtl/rheed_frame_ctrl_if.sv
// Host configuration, pipeline handshake and status bundle for rheed_frame_ctrl.
interface rheed_frame_ctrl_if #(
  parameter int IN_ROWS   = 20,
  parameter int IN_COLS   = 20,
  parameter int NUM_CROPS = 3,
  parameter int FRM_CNT_W = 16
);
  localparam int XW = $clog2(IN_COLS);
  localparam int YW = $clog2(IN_ROWS);
  localparam int CW = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1;

  logic                            cfg_wr_en;
  logic [CW-1:0]                   cfg_wr_idx;
  logic [XW-1:0]                   cfg_x0;
  logic [YW-1:0]                   cfg_y0;
  logic                            cfg_commit;
  logic                            frame_sof;
  logic                            seq_ap_idle;
  logic                            cn_ap_ready;
  logic                            cn_ap_done;
  logic                            out_tvalid;
  logic                            out_tready;
  logic                            ap_start;
  logic [NUM_CROPS-1:0][XW-1:0]    crop_x0;
  logic [NUM_CROPS-1:0][YW-1:0]    crop_y0;
  logic                            busy;
  logic                            frame_done;
  logic [FRM_CNT_W-1:0]            frame_cnt;
  logic [FRM_CNT_W-1:0]            drop_cnt;
  logic                            commit_pend;

  modport master (
    output cfg_wr_en, cfg_wr_idx, cfg_x0, cfg_y0, cfg_commit, frame_sof,
           seq_ap_idle, cn_ap_ready, cn_ap_done, out_tvalid, out_tready,
    input  ap_start, crop_x0, crop_y0, busy, frame_done, frame_cnt, drop_cnt,
           commit_pend
  );

  modport slave (
    input  cfg_wr_en, cfg_wr_idx, cfg_x0, cfg_y0, cfg_commit, frame_sof,
           seq_ap_idle, cn_ap_ready, cn_ap_done, out_tvalid, out_tready,
    output ap_start, crop_x0, crop_y0, busy, frame_done, frame_cnt, drop_cnt,
           commit_pend
  );

endinterface

// File: rtl/crop_cfg_regs.sv
// Shadow/active crop coordinate bank: host writes land in shadow, copy_en moves
// the whole shadow set to active in one cycle.
module crop_cfg_regs #(
  parameter int NUM_CROPS = 3,
  parameter int XW        = 5,
  parameter int YW        = 5,
  parameter int CW        = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_wr_en,
  input  logic [CW-1:0]                i_wr_idx,
  input  logic [XW-1:0]                i_wr_x0,
  input  logic [YW-1:0]                i_wr_y0,
  input  logic                         i_copy_en,
  output logic [NUM_CROPS-1:0][XW-1:0] o_act_x0,
  output logic [NUM_CROPS-1:0][YW-1:0] o_act_y0
);

  logic [NUM_CROPS-1:0][XW-1:0] r_sh_x0;
  logic [NUM_CROPS-1:0][YW-1:0] r_sh_y0;
  logic [NUM_CROPS-1:0][XW-1:0] r_act_x0;
  logic [NUM_CROPS-1:0][YW-1:0] r_act_y0;

  // Only indices that match an existing entry are written, so out-of-range
  // indices fall through without touching any entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_x0  <= '0;
      r_sh_y0  <= '0;
      r_act_x0 <= '0;
      r_act_y0 <= '0;
    end else begin
      for (int i = 0; i < NUM_CROPS; i++) begin
        if (i_wr_en && (i_wr_idx == CW'(i))) begin
          r_sh_x0[i] <= i_wr_x0;
          r_sh_y0[i] <= i_wr_y0;
        end
      end
      if (i_copy_en) begin
        r_act_x0 <= r_sh_x0;
        r_act_y0 <= r_sh_y0;
      end
    end
  end

  assign o_act_x0 = r_act_x0;
  assign o_act_y0 = r_act_y0;

endmodule

// File: rtl/rheed_frame_ctrl.sv
// Frame-level scheduler: starts the crop pipeline once per accepted frame,
// counts output beats, reports completion and drops frames that arrive while busy.
module rheed_frame_ctrl
  import rheed_pkg::*;
#(
  parameter int IN_ROWS   = 20,
  parameter int IN_COLS   = 20,
  parameter int OUT_ROWS  = 20,
  parameter int OUT_COLS  = 20,
  parameter int NUM_CROPS = 3,
  parameter int FRM_CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  rheed_frame_ctrl_if.slave bus
);

  localparam int XW    = $clog2(IN_COLS);
  localparam int YW    = $clog2(IN_ROWS);
  localparam int CW    = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1;
  localparam int BEATS = beats_per_frame(NUM_CROPS, OUT_ROWS, OUT_COLS);
  localparam int BW    = $clog2(BEATS + 1);

  frm_state_t           r_state;
  logic                 r_ap_start;
  logic                 r_busy;
  logic                 r_frame_done;
  logic                 r_commit_pend;
  logic                 r_done_seen;
  logic [BW-1:0]        r_beat_cnt;
  logic [FRM_CNT_W-1:0] r_frame_cnt;
  logic [FRM_CNT_W-1:0] r_drop_cnt;

  logic w_beat;
  logic w_beats_full;
  logic w_copy;

  assign w_beat       = bus.out_tvalid & bus.out_tready;
  assign w_beats_full = (r_beat_cnt == BW'(BEATS));
  // The copy is decided from the current state, so an sof in the same IDLE
  // cycle still sees the new coordinates once the frame starts.
  assign w_copy       = (r_state == IDLE) && r_commit_pend;

  crop_cfg_regs #(
    .NUM_CROPS (NUM_CROPS),
    .XW        (XW),
    .YW        (YW),
    .CW        (CW)
  ) u_cfg (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (bus.cfg_wr_en),
    .i_wr_idx  (bus.cfg_wr_idx),
    .i_wr_x0   (bus.cfg_x0),
    .i_wr_y0   (bus.cfg_y0),
    .i_copy_en (w_copy),
    .o_act_x0  (bus.crop_x0),
    .o_act_y0  (bus.crop_y0)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_ap_start    <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_commit_pend <= 1'b0;
      r_done_seen   <= 1'b0;
      r_beat_cnt    <= '0;
      r_frame_cnt   <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_ap_start   <= 1'b0;
      r_frame_done <= 1'b0;

      if (bus.frame_sof && (r_state != IDLE))
        r_drop_cnt <= r_drop_cnt + FRM_CNT_W'(1);

      // A new commit wins over the clearing copy so it is never lost.
      if (bus.cfg_commit)
        r_commit_pend <= 1'b1;
      else if (w_copy)
        r_commit_pend <= 1'b0;

      case (r_state)
        IDLE: begin
          if (bus.frame_sof) begin
            r_state <= ARM;
            r_busy  <= 1'b1;
          end
        end
        ARM: begin
          if (bus.seq_ap_idle && bus.cn_ap_ready) begin
            r_ap_start  <= 1'b1;
            r_beat_cnt  <= '0;
            r_done_seen <= 1'b0;
            r_state     <= RUN;
          end
        end
        RUN: begin
          if (w_beat && !w_beats_full)
            r_beat_cnt <= r_beat_cnt + BW'(1);
          if (bus.cn_ap_done)
            r_done_seen <= 1'b1;
          if (w_beats_full && (r_done_seen || bus.cn_ap_done))
            r_state <= DONE;
        end
        DONE: begin
          r_frame_done <= 1'b1;
          r_frame_cnt  <= r_frame_cnt + FRM_CNT_W'(1);
          r_busy       <= 1'b0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ap_start    = r_ap_start;
  assign bus.busy        = r_busy;
  assign bus.frame_done  = r_frame_done;
  assign bus.frame_cnt   = r_frame_cnt;
  assign bus.drop_cnt    = r_drop_cnt;
  assign bus.commit_pend = r_commit_pend;

endmodule

// File: tb/tb_rheed_frame_ctrl.sv
// Directed bench for rheed_frame_ctrl with a per-frame expectation scoreboard.
module tb_rheed_frame_ctrl;

  localparam int BEATS = 3 * 20 * 20;

  typedef struct {
    int unsigned fcnt;
    logic [14:0] x0;
    logic [14:0] y0;
  } exp_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   m_fcnt;
  int   m_drop;
  logic [2:0][4:0] m_x0;
  logic [2:0][4:0] m_y0;
  exp_t sb[$];

  rheed_frame_ctrl_if bus ();

  rheed_frame_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    m_fcnt++;
    e.fcnt = m_fcnt;
    e.x0   = m_x0;
    e.y0   = m_y0;
    sb.push_back(e);
  endtask

  task automatic cfg_write(input int idx, input int x, input int y);
    bus.cfg_wr_en  = 1'b1;
    bus.cfg_wr_idx = 2'(idx);
    bus.cfg_x0     = 5'(x);
    bus.cfg_y0     = 5'(y);
    tick();
    bus.cfg_wr_en  = 1'b0;
  endtask

  task automatic start_frame(input string tag);
    int lat;
    bus.frame_sof = 1'b1;
    tick();
    bus.frame_sof = 1'b0;
    push_exp();
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_ap_early"}, 32'(bus.ap_start), 32'd0);
    lat = 0;
    while (bus.ap_start !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "_ap_latency"}, 32'(lat), 32'd1);
    tick();
    chk({tag, "_ap_width"}, 32'(bus.ap_start), 32'd0);
  endtask

  // n beats back to back; cn_ap_done pulses together with beat done_at (0 = never)
  task automatic beats(input string tag, input int n, input int done_at);
    int bad_done;
    int bad_start;
    bad_done  = 0;
    bad_start = 0;
    for (int i = 1; i <= n; i++) begin
      bus.out_tvalid = 1'b1;
      bus.out_tready = 1'b1;
      bus.cn_ap_done = (i == done_at);
      tick();
      if (bus.frame_done !== 1'b0) bad_done++;
      if (bus.ap_start !== 1'b0) bad_start++;
    end
    bus.out_tvalid = 1'b0;
    bus.out_tready = 1'b0;
    bus.cn_ap_done = 1'b0;
    chk({tag, "_early_done"}, 32'(bad_done), 32'd0);
    chk({tag, "_extra_start"}, 32'(bad_start), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int   lat;
    exp_t e;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (bus.frame_done !== 1'b1 && lat < 100);
    chk({tag, "_done_latency"}, 32'(lat), 32'(exp_lat));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'(e.fcnt));
      chk({tag, "_crop_x0"}, 32'(bus.crop_x0), 32'(e.x0));
      chk({tag, "_crop_y0"}, 32'(bus.crop_y0), 32'(e.y0));
    end
    chk({tag, "_drop_cnt"}, 32'(bus.drop_cnt), 32'(m_drop));
    chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
    tick();
    chk({tag, "_done_width"}, 32'(bus.frame_done), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ap_start"}, 32'(bus.ap_start), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'd0);
    chk({tag, "_drop_cnt"}, 32'(bus.drop_cnt), 32'd0);
    chk({tag, "_commit_pend"}, 32'(bus.commit_pend), 32'd0);
    chk({tag, "_crop_x0"}, 32'(bus.crop_x0), 32'd0);
    chk({tag, "_crop_y0"}, 32'(bus.crop_y0), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_fcnt = 0;
    m_drop = 0;
    m_x0 = '0;
    m_y0 = '0;
    reset = 1'b1;
    bus.cfg_wr_en   = 1'b0;
    bus.cfg_wr_idx  = '0;
    bus.cfg_x0      = '0;
    bus.cfg_y0      = '0;
    bus.cfg_commit  = 1'b0;
    bus.frame_sof   = 1'b0;
    bus.seq_ap_idle = 1'b1;
    bus.cn_ap_ready = 1'b1;
    bus.cn_ap_done  = 1'b0;
    bus.out_tvalid  = 1'b0;
    bus.out_tready  = 1'b0;
    repeat (3) tick();
    chk_reset_state("rst");
    reset = 1'b0;
    tick();

    // T1: basic frame
    start_frame("t1");
    beats("t1", BEATS, BEATS);
    wait_done("t1", 2);

    // T2: commit during RUN takes effect only back in IDLE
    start_frame("t2");
    beats("t2a", 100, 0);
    cfg_write(1, 5, 7);
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    chk("t2_pend_set", 32'(bus.commit_pend), 32'd1);
    chk("t2_x0_held", 32'(bus.crop_x0[1]), 32'd0);
    beats("t2b", BEATS - 100, BEATS - 100);
    wait_done("t2", 2);
    m_x0[1] = 5'd5;
    m_y0[1] = 5'd7;
    chk("t2_x0_applied", 32'(bus.crop_x0), 32'(m_x0));
    chk("t2_y0_applied", 32'(bus.crop_y0), 32'(m_y0));
    chk("t2_pend_clr", 32'(bus.commit_pend), 32'd0);

    // T3: two sof during RUN are dropped; frame uses the 5/7 coordinates
    start_frame("t3");
    beats("t3a", 400, 0);
    for (int k = 0; k < 2; k++) begin
      bus.frame_sof = 1'b1;
      tick();
      bus.frame_sof = 1'b0;
      m_drop++;
    end
    chk("t3_drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
    beats("t3b", BEATS - 400, BEATS - 400);
    wait_done("t3", 2);

    // T4: done early, beats late; then beats first, done late
    start_frame("t4a");
    beats("t4a", BEATS, 600);
    wait_done("t4a", 2);
    start_frame("t4b");
    beats("t4b", BEATS, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4b_hold", 32'(bus.frame_done), 32'd0);
    end
    bus.cn_ap_done = 1'b1;
    tick();
    bus.cn_ap_done = 1'b0;
    chk("t4b_pre_done", 32'(bus.frame_done), 32'd0);
    wait_done("t4b", 1);

    // T5: commit overlapping copy, commit together with sof, stalled ARM
    cfg_write(0, 9, 3);
    bus.cfg_commit = 1'b1;
    tick();
    tick();
    bus.cfg_commit = 1'b0;
    m_x0[0] = 5'd9;
    m_y0[0] = 5'd3;
    chk("t5_pend_kept", 32'(bus.commit_pend), 32'd1);
    chk("t5_x0_copy", 32'(bus.crop_x0), 32'(m_x0));
    cfg_write(0, 2, 1);
    chk("t5_pend_clr", 32'(bus.commit_pend), 32'd0);
    chk("t5_x0_old_shadow", 32'(bus.crop_x0[0]), 32'd9);
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    bus.seq_ap_idle = 1'b0;
    bus.frame_sof = 1'b1;
    tick();
    bus.frame_sof = 1'b0;
    m_x0[0] = 5'd2;
    m_y0[0] = 5'd1;
    push_exp();
    chk("t5_sof_x0", 32'(bus.crop_x0), 32'(m_x0));
    chk("t5_sof_y0", 32'(bus.crop_y0), 32'(m_y0));
    chk("t5_sof_pend", 32'(bus.commit_pend), 32'd0);
    begin
      int early;
      int pulses;
      early = 0;
      for (int k = 0; k < 50; k++) begin
        tick();
        if (bus.ap_start !== 1'b0) early++;
      end
      chk("t5_stall_no_start", 32'(early), 32'd0);
      bus.seq_ap_idle = 1'b1;
      tick();
      chk("t5_start", 32'(bus.ap_start), 32'd1);
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (bus.ap_start === 1'b1) pulses++;
      end
      chk("t5_single_pulse", 32'(pulses), 32'd0);
    end
    beats("t5", BEATS, BEATS);
    wait_done("t5", 2);

    // T6: reset mid-frame, out-of-range index, clean restart
    start_frame("t6a");
    beats("t6a", 300, 0);
    reset = 1'b1;
    tick();
    chk_reset_state("t6_rst");
    reset = 1'b0;
    sb.delete();
    m_fcnt = 0;
    m_drop = 0;
    m_x0 = '0;
    m_y0 = '0;
    tick();
    cfg_write(2, 4, 2);
    cfg_write(3, 31, 31);
    bus.cfg_commit = 1'b1;
    tick();
    bus.cfg_commit = 1'b0;
    tick();
    m_x0[2] = 5'd4;
    m_y0[2] = 5'd2;
    chk("t6_idx_x0", 32'(bus.crop_x0), 32'(m_x0));
    chk("t6_idx_y0", 32'(bus.crop_y0), 32'(m_y0));
    start_frame("t6b");
    beats("t6b", BEATS, BEATS);
    wait_done("t6b", 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
